// File: rtl/amci_stream_writer.sv
// rtl/amci_stream_writer.sv - AXI-Stream to AMCI single-beat ring writer
// Writes each accepted beat to the next word of a ring and tracks write-response errors.
module amci_stream_writer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [COUNT_WIDTH-1:0]    MAX_WORDS,
  input  logic                      START,
  input  logic [AXI_DATA_WIDTH-1:0] AXIS_TDATA,
  input  logic                      AXIS_TVALID,
  input  logic                      AXIS_TLAST,
  output logic                      AXIS_TREADY,
  output logic [AXI_ADDR_WIDTH-1:0] AMCI_WADDR,
  output logic [AXI_DATA_WIDTH-1:0] AMCI_WDATA,
  output logic [2:0]                AMCI_WSIZE,
  output logic                      AMCI_WRITE,
  input  logic [1:0]                AMCI_WRESP,
  input  logic                      AMCI_WIDLE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [COUNT_WIDTH-1:0]    WORDS_WRITTEN,
  output logic                      ERR,
  output logic [AXI_ADDR_WIDTH-1:0] ERR_ADDR
);

  localparam int WSIZE = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [COUNT_WIDTH-1:0]    max_q, max_d;
  logic [COUNT_WIDTH-1:0]    index_q, index_d;
  logic                      tready_q, tready_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic [COUNT_WIDTH-1:0]    words_q, words_d;
  logic                      err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [COUNT_WIDTH-1:0]    index_inc;
  logic [AXI_ADDR_WIDTH-1:0] byte_off;

  // MAX_WORDS=0 needs no special case: index_inc wraps to 0 exactly at 2^CW.
  assign index_inc = index_q + 1'b1;
  assign byte_off  = AXI_ADDR_WIDTH'(index_q) << WSIZE;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    max_d      = max_q;
    index_d    = index_q;
    tready_d   = tready_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    last_d     = last_q;
    done_d     = 1'b0;
    words_d    = words_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          base_d   = BASE_ADDR;
          max_d    = MAX_WORDS;
          index_d  = '0;
          words_d  = '0;
          err_d    = 1'b0;
          tready_d = 1'b1;
          state_d  = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (AXIS_TVALID && tready_q) begin
          waddr_d  = base_q + byte_off;
          wdata_d  = AXIS_TDATA;
          last_d   = AXIS_TLAST;
          write_d  = 1'b1;
          tready_d = 1'b0;
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // The master's idle flag is stale while our own pulse is still out.
        if (!write_q && AMCI_WIDLE) begin
          words_d = words_q + 1'b1;
          index_d = (index_inc == max_q) ? '0 : index_inc;
          if (AMCI_WRESP != 2'b00) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = waddr_q;
          end
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tready_d = 1'b1;
            state_d  = WAIT_DATA;
          end
        end
      end
      default: begin
        tready_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      max_q      <= '0;
      index_q    <= '0;
      tready_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      words_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      max_q      <= max_d;
      index_q    <= index_d;
      tready_q   <= tready_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      last_q     <= last_d;
      done_q     <= done_d;
      words_q    <= words_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign AXIS_TREADY   = tready_q;
  assign AMCI_WADDR    = waddr_q;
  assign AMCI_WDATA    = wdata_q;
  assign AMCI_WSIZE    = 3'(WSIZE);
  assign AMCI_WRITE    = write_q;
  assign BUSY          = (state_q != IDLE);
  assign DONE          = done_q;
  assign WORDS_WRITTEN = words_q;
  assign ERR           = err_q;
  assign ERR_ADDR      = err_addr_q;

endmodule

// File: tb/tb_amci_stream_writer.sv
// tb/tb_amci_stream_writer.sv - directed bench for amci_stream_writer
// A behavioural AMCI master records every write; expectations are computed from the test arguments.
module tb_amci_stream_writer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] BASE_ADDR = '0;
  logic [15:0] MAX_WORDS = '0;
  logic        START = 1'b0;
  logic [31:0] AXIS_TDATA = '0;
  logic        AXIS_TVALID = 1'b0;
  logic        AXIS_TLAST = 1'b0;
  logic        AXIS_TREADY;
  logic [31:0] AMCI_WADDR;
  logic [31:0] AMCI_WDATA;
  logic [2:0]  AMCI_WSIZE;
  logic        AMCI_WRITE;
  logic [1:0]  m_wresp = 2'b00;
  logic        m_widle = 1'b1;
  logic        BUSY;
  logic        DONE;
  logic [15:0] WORDS_WRITTEN;
  logic        ERR;
  logic [31:0] ERR_ADDR;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [31:0] rec_addr[$];
  logic [31:0] rec_data[$];
  logic [31:0] err_mask = '0;
  bit          rand_delay = 1'b0;
  int          fixed_delay = 2;

  amci_stream_writer dut (
    .clk(clk), .resetn(resetn), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS), .START(START),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TLAST(AXIS_TLAST),
    .AXIS_TREADY(AXIS_TREADY), .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA),
    .AMCI_WSIZE(AMCI_WSIZE), .AMCI_WRITE(AMCI_WRITE), .AMCI_WRESP(m_wresp),
    .AMCI_WIDLE(m_widle), .BUSY(BUSY), .DONE(DONE), .WORDS_WRITTEN(WORDS_WRITTEN),
    .ERR(ERR), .ERR_ADDR(ERR_ADDR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: drops idle after each write pulse, answers after a delay.
  initial begin : master_model
    int d;
    int idx;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        m_widle = 1'b1;
        m_wresp = 2'b00;
      end else if (AMCI_WRITE) begin
        chk("write_while_master_busy", {63'd0, m_widle}, 64'd1);
        rec_addr.push_back(AMCI_WADDR);
        rec_data.push_back(AMCI_WDATA);
        idx = rec_addr.size() - 1;
        m_widle = 1'b0;
        d = rand_delay ? int'($urandom_range(0, 10)) : fixed_delay;
        for (int c = 0; c < d; c++) begin
          @(posedge clk); #1;
          if (!resetn) break;
          chk("write_during_busy", {63'd0, AMCI_WRITE}, 64'd0);
        end
        m_wresp = (idx < 32 && err_mask[idx]) ? 2'b10 : 2'b00;
        m_widle = 1'b1;
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (DONE) done_cnt++;
    end
  end

  task automatic pulse_start();
    START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input bit last);
    bit ok;
    bit rdy;
    ok = 1'b0;
    AXIS_TDATA  = data;
    AXIS_TLAST  = last;
    AXIS_TVALID = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rdy = AXIS_TREADY;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    AXIS_TVALID = 1'b0;
    AXIS_TLAST  = 1'b0;
    if (!ok) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_session(input string tag, input logic [31:0] base, input logic [15:0] maxw,
                             input int n, input logic [31:0] dbase, input bit gaps,
                             input bit poke_start, input bit restart);
    bit          seen;
    bit          exp_err;
    logic [31:0] exp_eaddr;
    logic [31:0] exp_addr;
    BASE_ADDR = base;
    MAX_WORDS = maxw;
    rec_addr.delete();
    rec_data.delete();
    done_cnt = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, {63'd0, BUSY}, 64'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      if (gaps) #1;
      send_beat(dbase + i, i == n - 1);
      if (poke_start && i == 0) begin
        BASE_ADDR = 32'h9000;
        MAX_WORDS = 16'd1;
        pulse_start();
        chk({tag, "_busy_after_ignored_start"}, {63'd0, BUSY}, 64'd1);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_busy_at_done"}, {63'd0, BUSY}, 64'd0);
    chk({tag, "_words"}, {48'd0, WORDS_WRITTEN}, 64'(n));
    exp_err = 1'b0;
    exp_eaddr = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (err_mask[i]) begin
        exp_err = 1'b1;
        exp_eaddr = base + ((maxw == 0) ? i : (i % maxw)) * 4;
      end
    end
    chk({tag, "_err"}, {63'd0, ERR}, {63'd0, exp_err});
    if (exp_err) chk({tag, "_err_addr"}, {32'd0, ERR_ADDR}, {32'd0, exp_eaddr});
    if (restart) begin
      START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      chk({tag, "_restart_busy"}, {63'd0, BUSY}, 64'd1);
      chk({tag, "_restart_tready"}, {63'd0, AXIS_TREADY}, 64'd1);
      chk({tag, "_restart_err_clr"}, {63'd0, ERR}, 64'd0);
    end else begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_write_count"}, 64'(rec_addr.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rec_addr.size()) begin
        exp_addr = base + ((maxw == 0) ? i : (i % maxw)) * 4;
        chk($sformatf("%s_addr%0d", tag, i), {32'd0, rec_addr[i]}, {32'd0, exp_addr});
        chk($sformatf("%s_data%0d", tag, i), {32'd0, rec_data[i]}, {32'd0, dbase + i});
      end
    end
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", {63'd0, AXIS_TREADY}, 64'd0);
    chk("rst_write", {63'd0, AMCI_WRITE}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_done", {63'd0, DONE}, 64'd0);
    chk("rst_err", {63'd0, ERR}, 64'd0);
    chk("rst_words", {48'd0, WORDS_WRITTEN}, 64'd0);
    chk("rst_waddr", {32'd0, AMCI_WADDR}, 64'd0);
    chk("wsize", {61'd0, AMCI_WSIZE}, 64'd2);
    resetn = 1'b1;
    @(posedge clk); #1;

    AXIS_TVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_tready", {63'd0, AXIS_TREADY}, 64'd0);
    chk("idle_no_write", 64'(rec_addr.size()), 64'd0);
    AXIS_TVALID = 1'b0;

    run_session("t1", 32'h1000, 16'd0, 4, 32'hA0, 1'b0, 1'b0, 1'b0);
    run_session("t2", 32'h1000, 16'd3, 5, 32'hB0, 1'b0, 1'b0, 1'b0);
    run_session("max1", 32'h3000, 16'd1, 3, 32'hC0, 1'b0, 1'b0, 1'b0);
    rand_delay = 1'b1;
    run_session("t4", 32'h4000, 16'd5, 8, 32'hD0, 1'b1, 1'b0, 1'b0);
    rand_delay = 1'b0;
    fixed_delay = 6;
    run_session("t5", 32'h2000, 16'd0, 3, 32'hE0, 1'b0, 1'b1, 1'b0);
    fixed_delay = 1;
    err_mask = 32'b01010;
    run_session("t3", 32'h1000, 16'd0, 5, 32'hF0, 1'b0, 1'b0, 1'b0);
    err_mask = '0;
    run_session("t6", 32'h5000, 16'd4, 1, 32'h55, 1'b0, 1'b0, 1'b1);

    // Left in WAIT_DATA by the restart; drop reset mid-cycle and look before any edge.
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("arst_tready", {63'd0, AXIS_TREADY}, 64'd0);
    chk("arst_busy", {63'd0, BUSY}, 64'd0);
    chk("arst_waddr", {32'd0, AMCI_WADDR}, 64'd0);
    chk("arst_wdata", {32'd0, AMCI_WDATA}, 64'd0);
    chk("arst_err_addr", {32'd0, ERR_ADDR}, 64'd0);
    chk("arst_words", {48'd0, WORDS_WRITTEN}, 64'd0);
    #20;
    resetn = 1'b1;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
